// File: rtl/mod_sha256_compress.sv
// SHA-256 compression core: one round per accepted W/K word, 64 rounds per block,
// chaining-value feed-forward registered on entry to FINAL.
module mod_sha256_compress #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:255] h_in,
  input  logic         w_valid,
  input  logic [0:31]  w_in,
  input  logic [0:31]  k_in,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [0:255] h_out
);

  localparam int unsigned CNT_W = $clog2(ROUNDS);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0][31:0]    wk_q, wk_d;     // working registers, index 0 = a ... 7 = h
  logic [7:0][31:0]    hs_q, hs_d;     // saved chaining value for the feed-forward
  logic [0:255]        h_out_q, h_out_d;
  logic                w_ready_q, w_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0][31:0]    rnd;            // working registers after one round
  logic [31:0]         w_word, k_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Single SHA-256 round on the current working registers
  always_comb begin
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] s0, s1, ch, maj, t1, t2;
    w_word = w_in;
    k_word = k_in;
    a = wk_q[0]; b = wk_q[1]; c = wk_q[2]; d = wk_q[3];
    e = wk_q[4]; f = wk_q[5]; g = wk_q[6]; h = wk_q[7];
    s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    ch  = (e & f) ^ (~e & g);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t1  = h + s1 + ch + k_word + w_word;
    t2  = s0 + maj;
    rnd[0] = t1 + t2;
    rnd[1] = a;
    rnd[2] = b;
    rnd[3] = c;
    rnd[4] = d + t1;
    rnd[5] = e;
    rnd[6] = f;
    rnd[7] = g;
  end

  // Next-state, datapath update and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wk_d    = wk_q;
    hs_d    = hs_q;
    h_out_d = h_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            wk_d[i] = h_in[32*i +: 32];
            hs_d[i] = h_in[32*i +: 32];
          end
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (w_valid && w_ready_q) begin
          wk_d  = rnd;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_RND) begin
            // Feed-forward uses the final round result so H_OUT is valid with DONE
            for (int i = 0; i < 8; i++) begin
              h_out_d[32*i +: 32] = hs_q[i] + rnd[i];
            end
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    w_ready_d = (state_d == ROUND);
    busy_d    = (state_d == ROUND) || (state_d == FINAL);
    done_d    = (state_d == FINAL);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wk_q      <= '0;
      hs_q      <= '0;
      h_out_q   <= '0;
      w_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wk_q      <= wk_d;
      hs_q      <= hs_d;
      h_out_q   <= h_out_d;
      w_ready_q <= w_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w_ready = w_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign h_out   = h_out_q;

endmodule

// File: tb/tb_mod_sha256_compress.sv
// Directed bench for the SHA-256 compression core: known digests, stalls, reset, chaining.
module tb_mod_sha256_compress;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:255] h_in;
  logic         w_valid;
  logic [0:31]  w_in;
  logic [0:31]  k_in;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [0:255] h_out;

  mod_sha256_compress #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .h_in(h_in),
    .w_valid(w_valid), .w_in(w_in), .k_in(k_in),
    .w_ready(w_ready), .busy(busy), .done(done), .h_out(h_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] kt[64];
  logic [31:0] wsch[64];

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_L1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_L2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_L = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    string        name;
    logic [255:0] hin;
    logic [511:0] blk;
    bit           gaps;
    bit           poke;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[4];

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule expansion (the DUT receives W_t directly, so the bench computes it)
  task automatic expand(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) wsch[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(wsch[t-15], 7) ^ rr(wsch[t-15], 18) ^ (wsch[t-15] >> 3);
      s1 = rr(wsch[t-2], 17) ^ rr(wsch[t-2], 19) ^ (wsch[t-2] >> 10);
      wsch[t] = s1 + wsch[t-7] + s0 + wsch[t-16];
    end
  endtask

  // Runs one block. lat counts cycles inclusively: START cycle is 1, DONE cycle is lat.
  // Returns at the falling edge inside the DONE cycle.
  task automatic run_block(input string name, input logic [255:0] hin, input logic [511:0] blk,
                           input bit gaps, input bit poke, output logic [255:0] hout,
                           output int lat, output int hs, output int gapc);
    bit got;
    expand(blk);
    got = 1'b0; hs = 0; gapc = 0; hout = '0;
    @(posedge clk); #1;
    start = 1'b1; h_in = hin; w_valid = 1'b0; lat = 1;
    @(negedge clk);
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (poke && hs == 10) begin
        start = 1'b1;
        h_in  = ~hin;
      end
      w_valid = (gaps && hs < 64) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (hs < 64) begin
        w_in = wsch[hs];
        k_in = kt[hs];
      end
      @(negedge clk);
      if (done) begin
        got  = 1'b1;
        hout = h_out;
      end else if (w_ready && w_valid) begin
        hs++;
      end else if (w_ready) begin
        gapc++;
      end
    end
    chk({name, " done seen"}, 256'(got), 256'(1));
    start = 1'b0;
  endtask

  logic [255:0] hout, mid;
  int lat, hs, gapc;

  initial begin
    kt = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    vecs[0] = '{name: "abc",        hin: IV, blk: BLK_ABC,   gaps: 1'b0, poke: 1'b0, exp: D_ABC};
    vecs[1] = '{name: "abc_gaps",   hin: IV, blk: BLK_ABC,   gaps: 1'b1, poke: 1'b0, exp: D_ABC};
    vecs[2] = '{name: "empty",      hin: IV, blk: BLK_EMPTY, gaps: 1'b0, poke: 1'b0, exp: D_EMPTY};
    vecs[3] = '{name: "start_poke", hin: IV, blk: BLK_ABC,   gaps: 1'b0, poke: 1'b1, exp: D_ABC};

    rst_n = 1'b0; start = 1'b0; h_in = '0; w_valid = 1'b0; w_in = '0; k_in = '0;
    #2;
    chk("reset busy",    256'(busy),    256'(0));
    chk("reset w_ready", 256'(w_ready), 256'(0));
    chk("reset done",    256'(done),    256'(0));
    chk("reset h_out",   256'(h_out),   256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // W_VALID outside ROUND must not start anything
    @(posedge clk); #1; w_valid = 1'b1;
    @(negedge clk);
    chk("idle w_valid busy", 256'(busy), 256'(0));
    w_valid = 1'b0;

    foreach (vecs[i]) begin
      run_block(vecs[i].name, vecs[i].hin, vecs[i].blk, vecs[i].gaps, vecs[i].poke, hout, lat, hs, gapc);
      chk({vecs[i].name, " digest"},     hout,        vecs[i].exp);
      chk({vecs[i].name, " handshakes"}, 256'(hs),    256'(64));
      chk({vecs[i].name, " latency"},    256'(lat),   256'(66 + gapc));
      chk({vecs[i].name, " busy@done"},  256'(busy),  256'(1));
      @(negedge clk);
      chk({vecs[i].name, " done pulse"}, 256'(done),  256'(0));
      chk({vecs[i].name, " idle"},       256'(busy),  256'(0));
      chk({vecs[i].name, " hold"},       256'(h_out), vecs[i].exp);
    end

    // Two-block chaining; the first digest is fed back as the chaining input
    run_block("blk1", IV, BLK_L1, 1'b0, 1'b0, mid, lat, hs, gapc);
    @(negedge clk);
    run_block("blk2", mid, BLK_L2, 1'b1, 1'b0, hout, lat, hs, gapc);
    chk("two-block digest", hout, D_L);

    // START in the DONE cycle is ignored; START on the following IDLE cycle is accepted
    run_block("abc_b2b", IV, BLK_ABC, 1'b0, 1'b0, hout, lat, hs, gapc);
    start = 1'b1; h_in = IV; w_valid = 1'b0;
    @(negedge clk);
    chk("start in FINAL ignored", 256'(busy), 256'(0));
    @(negedge clk);
    chk("start after FINAL busy",    256'(busy),    256'(1));
    chk("start after FINAL w_ready", 256'(w_ready), 256'(1));
    start = 1'b0;

    // Stream 31 rounds into that block, then reset in the middle of it
    expand(BLK_ABC);
    for (int r = 0; r < 31; r++) begin
      w_valid = 1'b1; w_in = wsch[r]; k_in = kt[r];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid reset busy",    256'(busy),    256'(0));
    chk("mid reset w_ready", 256'(w_ready), 256'(0));
    chk("mid reset h_out",   256'(h_out),   256'(0));
    chk("mid reset done",    256'(done),    256'(0));
    @(negedge clk);
    chk("reset low busy", 256'(busy), 256'(0));
    rst_n = 1'b1; w_valid = 1'b0;
    @(negedge clk);
    chk("after reset idle", 256'(busy), 256'(0));
    run_block("abc_after_reset", IV, BLK_ABC, 1'b0, 1'b0, hout, lat, hs, gapc);
    chk("abc after reset digest",  hout,      D_ABC);
    chk("abc after reset latency", 256'(lat), 256'(66));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mod_sha256_compress.md
MOD_SHA256_COMPRESS -- requirements
Module: MOD_SHA256_COMPRESS

Interface
REQ-001 SHALL have parameter ROUNDS, default 64: number of compression rounds per block. Only 64 is supported.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port START, input, 1: begin a block; H_IN is sampled on the same edge.
REQ-005 SHALL have port H_IN, input, [0:255]: chaining value H0..H7, with H0 at bits 0-31 and bit 0 the MSB.
REQ-006 SHALL have port W_VALID, input, 1: W_IN and K_IN hold valid data for the current round.
REQ-007 SHALL have port W_IN, input, [0:31]: message schedule word W_t.
REQ-008 SHALL have port K_IN, input, [0:31]: round constant K_t.
REQ-009 SHALL have port W_READY, output, 1: the block accepts W_IN and K_IN this cycle.
REQ-010 SHALL have port BUSY, output, 1: a block is in progress.
REQ-011 SHALL have port DONE, output, 1: one-cycle pulse when H_OUT is updated.
REQ-012 SHALL have port H_OUT, output, [0:255]: updated chaining value, same layout as H_IN.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, FINAL; reset state is IDLE.
REQ-014 In IDLE, START=1 SHALL load working registers a..h and a saved copy Hs from H_IN, clear the round counter to 0, and enter ROUND.
REQ-015 START SHALL be ignored in ROUND and FINAL.
REQ-016 W_READY SHALL be 1 only in ROUND; a round executes only on an edge with W_VALID=1 and W_READY=1.
REQ-017 W_VALID SHALL be ignored outside ROUND; a cycle with W_VALID=0 in ROUND SHALL hold all state.
REQ-018 Each accepted round SHALL compute, all sums mod 2^32:
- T1 = h + S1(e) + Ch(e,f,g) + K_IN + W_IN
- T2 = S0(a) + Maj(a,b,c)
- then h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
REQ-019 The round functions SHALL be:
- Ch = (e AND f) XOR ((NOT e) AND g)
- Maj = (a AND b) XOR (a AND c) XOR (b AND c)
- S0 = ROTR2 XOR ROTR13 XOR ROTR22
- S1 = ROTR6 XOR ROTR11 XOR ROTR25
REQ-020 The round counter SHALL increment on each accepted round; acceptance at counter=63 SHALL enter FINAL.
REQ-021 In FINAL, the block SHALL:
- set H_OUT word i to Hs_i + working_i mod 2^32,
- assert DONE for exactly one cycle,
- return to IDLE on the next edge.
REQ-022 Latency: START to DONE SHALL be exactly 66 cycles when W_VALID is held at 1; each W_VALID=0 cycle in ROUND SHALL add one cycle.
REQ-023 H_OUT SHALL hold its value until the next FINAL.
REQ-024 BUSY SHALL be 1 in ROUND and FINAL, and 0 in IDLE.
REQ-025 START may be asserted in the same cycle that DONE is 1; it SHALL be ignored because the block is in FINAL.
REQ-026 START may be asserted on the first IDLE cycle after FINAL; it SHALL be accepted.

Reset
REQ-027 RST_N=0 SHALL immediately and asynchronously force:
- state to IDLE
- counter to 0
- a..h, Hs and H_OUT to 0
- W_READY, BUSY and DONE to 0
This applies at any point, including mid-block.
REQ-028 After RST_N is released, the block SHALL wait for a new START; any partially processed block SHALL be discarded.

Verification
REQ-029 The bench SHALL cover:
- IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, with the "abc" padded-block schedule and K streamed with W_VALID=1 -> H_OUT = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, and DONE exactly 66 cycles after START.
- Same stimulus with pseudo-random W_VALID gaps -> identical H_OUT; exactly 64 handshakes; DONE delayed by the number of gap cycles.
- IV with the empty-message padded block -> H_OUT = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- RST_N pulsed low after round 30 -> during the low phase BUSY=0, W_READY=0, H_OUT=0; after release, a fresh "abc" run gives the correct digest.
- START pulsed during ROUND with a different H_IN -> no effect; digest unchanged.
- Two-block chaining: H_IN = first digest, second block streamed -> correct 448-bit-message digest ("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq") = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
